// File: rtl/comb_ontransit_pkg.sv
// Shared state encoding and counter-width helper for the multi-channel on-transit FSM.
package comb_ontransit_pkg;

  localparam logic [1:0] StCodeIdle = 2'd0;
  localparam logic [1:0] StCodeRun  = 2'd1;
  localparam logic [1:0] StCodeCool = 2'd2;

  typedef enum logic [1:0] {
    StIdle = StCodeIdle,
    StRun  = StCodeRun,
    StCool = StCodeCool
  } state_e;

  // Wide enough to hold the largest terminal count of any phase.
  function automatic int unsigned calc_cw(input int unsigned min_run,
                                          input int unsigned max_run,
                                          input int unsigned holdoff);
    int unsigned m;
    m = min_run;
    if (max_run > m) m = max_run;
    if (holdoff > m) m = holdoff;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/comb_ontransit_ch.sv
// One on-transit channel: IDLE/RUN/COOL FSM with saturating counter and go/stop/timeout pulses.
module comb_ontransit_ch
  import comb_ontransit_pkg::*;
#(
  parameter int unsigned MIN_RUN = 4,
  parameter int unsigned MAX_RUN = 16,
  parameter int unsigned HOLDOFF = 2,
  parameter int unsigned CW      = calc_cw(MIN_RUN, MAX_RUN, HOLDOFF)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       do_i,
  output logic       g_o,
  output logic       s_o,
  output logic       to_o,
  output logic       busy_o,
  output logic [1:0] st_o
);

  localparam logic [CW-1:0] MinLast   = CW'(MIN_RUN - 1);
  localparam logic [CW-1:0] MaxLast   = CW'((MAX_RUN > 0) ? MAX_RUN - 1 : 0);
  localparam logic [CW-1:0] HoldLast  = CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam state_e        StopState = (HOLDOFF == 0) ? StIdle : StCool;
  localparam bit            TimeoutEn = (MAX_RUN != 0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          timeout, stop_req;
  logic          g, s, to;

  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
  // Timeout does not look at do, so it wins when a voluntary stop lands on the same cycle.
  assign timeout  = TimeoutEn && (cnt_q == MaxLast);
  assign stop_req = !do_i && (cnt_q >= MinLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    g       = 1'b0;
    s       = 1'b0;
    to      = 1'b0;
    case (state_q)
      StIdle: begin
        if (do_i) begin
          state_d = StRun;
          cnt_d   = '0;
          g       = 1'b1;
        end
      end
      StRun: begin
        cnt_d = cnt_inc;
        if (timeout || stop_req) begin
          state_d = StopState;
          cnt_d   = '0;
          s       = 1'b1;
          to      = timeout;
        end
      end
      StCool: begin
        cnt_d = cnt_inc;
        if (cnt_q == HoldLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign g_o    = g & ~rst_i;
  assign s_o    = s & ~rst_i;
  assign to_o   = to & ~rst_i;
  assign busy_o = (state_q != StIdle);
  assign st_o   = state_q;

endmodule

// File: rtl/comb_ontransit_n.sv
// N-channel on-transit FSM array; define COMB_ONTRANSIT_REG_OUT_EN to register g/s/to by one cycle.
module comb_ontransit_n #(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned MIN_RUN = 4,
  parameter int unsigned MAX_RUN = 16,
  parameter int unsigned HOLDOFF = 2
) (
  input  logic [0:0]        clk_i,
  input  logic              rst_i,
  input  logic [N_CH-1:0]   do_i,
  output logic [N_CH-1:0]   g_o,
  output logic [N_CH-1:0]   s_o,
  output logic [N_CH-1:0]   to_o,
  output logic [N_CH-1:0]   busy_o,
  output logic [2*N_CH-1:0] st_o
);

  logic [N_CH-1:0] g_c, s_c, to_c;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    comb_ontransit_ch #(
      .MIN_RUN(MIN_RUN),
      .MAX_RUN(MAX_RUN),
      .HOLDOFF(HOLDOFF)
    ) u_ch (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .do_i  (do_i[i]),
      .g_o   (g_c[i]),
      .s_o   (s_c[i]),
      .to_o  (to_c[i]),
      .busy_o(busy_o[i]),
      .st_o  (st_o[2*i+1 -: 2])
    );
  end

`ifdef COMB_ONTRANSIT_REG_OUT_EN
  logic [N_CH-1:0] g_q, s_q, to_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      g_q  <= '0;
      s_q  <= '0;
      to_q <= '0;
    end else begin
      g_q  <= g_c;
      s_q  <= s_c;
      to_q <= to_c;
    end
  end

  assign g_o  = g_q;
  assign s_o  = s_q;
  assign to_o = to_q;
`else
  assign g_o  = g_c;
  assign s_o  = s_c;
  assign to_o = to_c;
`endif

endmodule

// File: doc/comb_ontransit_n.md
Name: comb_ontransit_n

Overview:
- Parametrised, multi-channel successor of the single-channel on-transit FSM.
- Each of N_CH channels runs an IDLE/RUN/COOL FSM driven by its do bit.
- Emits combinational one-cycle go (g) and stop (s) pulses in the cycle the transition is taken.
- Adds a minimum run length, an optional run timeout and a post-stop hold-off; sits between request sources and downstream start/stop consumers.

Parameters:
N_CH, 2, number of independent channels (>=1)
MIN_RUN, 4, minimum cycles in RUN before a stop is accepted (>=1)
MAX_RUN, 16, RUN timeout in cycles; 0 disables timeout (if nonzero, must be >= MIN_RUN)
HOLDOFF, 2, cycles spent in COOL after a stop; 0 means RUN goes directly to IDLE

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
do   in  N_CH  per-channel run request, level-sensitive
g    out  N_CH  go pulse, high in the IDLE->RUN transition cycle
s    out  N_CH  stop pulse, high in the RUN->COOL/IDLE transition cycle
to   out  N_CH  timeout flag, high together with s when the stop was forced by MAX_RUN
busy out  N_CH  channel state != IDLE
st   out  2*N_CH  per-channel state code, channel i at bits [2i+1:2i]

Behaviour:
- Single clock; synchronous, active-high rst.
- While rst=1: every channel goes to IDLE with cnt=0 on the next edge; g, s and to are forced to 0 combinationally.
- Reset mid-RUN or mid-COOL: no s pulse is generated.
- State codes: IDLE=0, RUN=1, COOL=2; code 3 is illegal and recovers to IDLE on the next edge with no pulse.
- Per-channel counter cnt is CW = $clog2(max(MIN_RUN, MAX_RUN, HOLDOFF) + 1) bits and saturates.
- IDLE:
  - do=1: next state RUN, cnt<=0, g=1 in the same cycle (combinational from state and do).
  - do=0: stay in IDLE.
- RUN: cnt increments each cycle.
  - Stop: do=0 and cnt >= MIN_RUN-1. Go to COOL (or IDLE if HOLDOFF=0), s=1, cnt<=0.
  - Timeout: MAX_RUN != 0 and cnt == MAX_RUN-1 with do still 1. Forced stop with the same transition plus s=1 and to=1.
  - If stop and timeout are both true in one cycle, the timeout takes priority: to=1.
- COOL: do is ignored. cnt increments. When cnt == HOLDOFF-1, go to IDLE with no pulse.
- Re-arm: if do is still 1 on arrival in IDLE, the IDLE->RUN transition (and g) occurs in the next cycle.
- Guaranteed pulse spacing: at most one g per channel every MIN_RUN+HOLDOFF+1 cycles. g and s are never high together on one channel.
- Channels are fully independent; simultaneous events on different channels all fire in the same cycle.
- Latency:
  - g: 0 cycles from do rising while IDLE.
  - Earliest s: MIN_RUN cycles after g.
  - busy: rises on the edge after g and falls on the edge that enters IDLE.

Optional Feature:
COMB_ONTRANSIT_REG_OUT_EN
- Defined: g, s and to are registered, so each pulse appears exactly one cycle after the transition cycle, still one cycle wide. The registers clear on rst.
- Not defined: g, s and to are combinational, 0-cycle as above.
- busy and st are unaffected in both cases.

Decomposition:
- Package comb_ontransit_pkg holds:
  - state typedef (2-bit enum IDLE/RUN/COOL);
  - state code constants;
  - a function computing CW from the parameters.
- Sub-module comb_ontransit_ch: one channel's FSM, counter and pulse logic, with scalar do/g/s/to/busy and 2-bit st.
- Top level is a generate loop over N_CH plus the optional output register stage.

Test Plan:
- Defaults, macro off. do[0] rises at cycle 10 and stays high 6 cycles -> g[0]=1 at cycle 10 only; s[0]=1 at cycle 16; busy[0] high cycles 11..18; IDLE at 19.
- do[0] pulsed high for 1 cycle -> g[0] at the pulse; s[0] delayed until cnt=3, i.e. 4 cycles after g.
- do[1] held high 30 cycles -> g[1], then s[1]=1 and to[1]=1 together 16 cycles later; after COOL (2 cycles) g[1] fires again.
- do=2'b11 applied simultaneously -> g=2'b11 in the same cycle; identical s timing on both channels; no cross-channel interaction.
- rst asserted 3 cycles after g[0] while in RUN -> no s pulse; st=0 and busy=0 after the edge; g can fire again on the cycle after rst drops.
- With COMB_ONTRANSIT_REG_OUT_EN defined and the first scenario repeated -> g[0] at cycle 11, s[0] at cycle 17; busy timing unchanged.
